label_equiv_table: RTL and testbench

//  Union-find equivalence table directly downstream of the connected-component labeler.

---
 rtl/label_pkg.sv | 27 ++
 rtl/label_parent_mem.sv | 34 +++
 rtl/label_equiv_table.sv | 159 +++++++++++++++
 tb/tb_label_equiv_table.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/label_pkg.sv
// Shared types and constants for the label equivalence table.
package label_pkg;

  localparam int LABEL_WIDTH = 8;
  localparam int MAX_LABELS  = 2 ** LABEL_WIDTH;

  typedef logic [LABEL_WIDTH-1:0] label_t;

  localparam label_t BG_LABEL = '0;

  typedef enum logic [2:0] {
    IDLE,
    FIND_A,
    FIND_B,
    LINK,
    RES_FIND
  } equiv_state_t;

  function automatic label_t min_label(input label_t a, input label_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic label_t max_label(input label_t a, input label_t b);
    return (a < b) ? b : a;
  endfunction

endpackage

// File: rtl/label_parent_mem.sv
// Parent-pointer storage: one entry per label, two combinational read ports,
// one synchronous write port, whole-table re-initialisation on clear.
module label_parent_mem
  import label_pkg::*;
(
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [LABEL_WIDTH-1:0] wr_addr,
  input  logic [LABEL_WIDTH-1:0] wr_data,
  input  logic [LABEL_WIDTH-1:0] rd_addr_a,
  input  logic [LABEL_WIDTH-1:0] rd_addr_b,
  output logic [LABEL_WIDTH-1:0] rd_data_a,
  output logic [LABEL_WIDTH-1:0] rd_data_b
);

  label_t parent_reg [MAX_LABELS];

  // Clearing makes every label its own root in a single cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < MAX_LABELS; i++) begin
        parent_reg[i] <= LABEL_WIDTH'(i);
      end
    end else if (wr_en) begin
      assert (wr_data < wr_addr);
      parent_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = parent_reg[rd_addr_a];
  assign rd_data_b = parent_reg[rd_addr_b];

endmodule

// File: rtl/label_equiv_table.sv
// Union-find equivalence table: tracks label merges during a frame and
// answers root lookups afterwards, one pointer hop per clock.
module label_equiv_table
  import label_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   new_label_valid,
  input  logic [LABEL_WIDTH-1:0] new_label_value,
  input  logic                   merge_labels,
  input  logic [LABEL_WIDTH-1:0] merge_a,
  input  logic [LABEL_WIDTH-1:0] merge_b,
  output logic                   in_ready,
  input  logic                   resolve_req,
  input  logic [LABEL_WIDTH-1:0] resolve_label,
  output logic                   resolve_valid,
  output logic [LABEL_WIDTH-1:0] resolve_root,
  output logic [LABEL_WIDTH-1:0] label_count,
  output logic                   overflow
);

  equiv_state_t state_reg, state_next;
  label_t       ra_reg, ra_next;
  label_t       rb_reg, rb_next;
  label_t       rr_reg, rr_next;
  label_t       label_count_reg, label_count_next;
  logic         overflow_reg, overflow_next;
  logic         resolve_valid_reg, resolve_valid_next;
  label_t       resolve_root_reg, resolve_root_next;

  logic   mem_clear;
  logic   wr_en;
  label_t wr_addr, wr_data;
  label_t rd_addr_a, parent_a, parent_b;
  logic   merge_ok;

  assign mem_clear = rst | frame_start;
  assign rd_addr_a = (state_reg == RES_FIND) ? rr_reg : ra_reg;

  label_parent_mem u_parent_mem (
    .clk       (clk),
    .clear     (mem_clear),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rb_reg),
    .rd_data_a (parent_a),
    .rd_data_b (parent_b)
  );

  assign merge_ok = merge_labels && (merge_a != merge_b) &&
                    (merge_a != BG_LABEL) && (merge_b != BG_LABEL);

  always_comb begin
    state_next         = state_reg;
    ra_next            = ra_reg;
    rb_next            = rb_reg;
    rr_next            = rr_reg;
    label_count_next   = label_count_reg;
    overflow_next      = overflow_reg;
    resolve_valid_next = 1'b0;
    resolve_root_next  = resolve_root_reg;
    wr_en              = 1'b0;
    wr_addr            = max_label(ra_reg, rb_reg);
    wr_data            = min_label(ra_reg, rb_reg);

    case (state_reg)
      IDLE: begin
        if (new_label_valid && (new_label_value != BG_LABEL)) begin
          if (new_label_value > label_count_reg) begin
            label_count_next = new_label_value;
          end else begin
            overflow_next = 1'b1;
          end
        end
        // The requester still holds resolve_req during the result pulse, so a
        // request seen in that cycle is the one just answered, not a new one.
        if (merge_labels) begin
          if (merge_ok) begin
            ra_next    = merge_a;
            rb_next    = merge_b;
            state_next = FIND_A;
          end
        end else if (resolve_req && !resolve_valid_reg) begin
          rr_next    = resolve_label;
          state_next = RES_FIND;
        end
      end
      FIND_A: begin
        if (parent_a == ra_reg) begin
          state_next = FIND_B;
        end else begin
          ra_next = parent_a;
        end
      end
      FIND_B: begin
        if (parent_b == rb_reg) begin
          state_next = LINK;
        end else begin
          rb_next = parent_b;
        end
      end
      LINK: begin
        wr_en      = (ra_reg != rb_reg);
        state_next = IDLE;
      end
      RES_FIND: begin
        if (parent_a == rr_reg) begin
          resolve_valid_next = 1'b1;
          resolve_root_next  = rr_reg;
          state_next         = IDLE;
        end else begin
          rr_next = parent_a;
        end
      end
      default: state_next = IDLE;
    endcase

    if (frame_start) begin
      state_next         = IDLE;
      label_count_next   = BG_LABEL;
      overflow_next      = 1'b0;
      resolve_valid_next = 1'b0;
      resolve_root_next  = BG_LABEL;
      wr_en              = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      ra_reg            <= BG_LABEL;
      rb_reg            <= BG_LABEL;
      rr_reg            <= BG_LABEL;
      label_count_reg   <= BG_LABEL;
      overflow_reg      <= 1'b0;
      resolve_valid_reg <= 1'b0;
      resolve_root_reg  <= BG_LABEL;
    end else begin
      state_reg         <= state_next;
      ra_reg            <= ra_next;
      rb_reg            <= rb_next;
      rr_reg            <= rr_next;
      label_count_reg   <= label_count_next;
      overflow_reg      <= overflow_next;
      resolve_valid_reg <= resolve_valid_next;
      resolve_root_reg  <= resolve_root_next;
    end
  end

  assign in_ready      = (state_reg == IDLE);
  assign resolve_valid = resolve_valid_reg;
  assign resolve_root  = resolve_root_reg;
  assign label_count   = label_count_reg;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_label_equiv_table.sv
// Randomised self-checking bench for label_equiv_table against a plain
// union-find reference model.
module tb_label_equiv_table;

  logic       clk = 1'b0;
  logic       rst, frame_start, new_label_valid, merge_labels, resolve_req;
  logic [7:0] new_label_value, merge_a, merge_b, resolve_label;
  logic       in_ready, resolve_valid, overflow;
  logic [7:0] resolve_root, label_count;

  int total = 0;
  int bad   = 0;

  int m_parent [256];
  int m_count;
  bit m_ovf;

  always #5 clk = ~clk;

  label_equiv_table dut (
    .clk             (clk),
    .rst             (rst),
    .frame_start     (frame_start),
    .new_label_valid (new_label_valid),
    .new_label_value (new_label_value),
    .merge_labels    (merge_labels),
    .merge_a         (merge_a),
    .merge_b         (merge_b),
    .in_ready        (in_ready),
    .resolve_req     (resolve_req),
    .resolve_label   (resolve_label),
    .resolve_valid   (resolve_valid),
    .resolve_root    (resolve_root),
    .label_count     (label_count),
    .overflow        (overflow)
  );

  // Result pulses must never be back to back.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (resolve_valid === 1'b1) begin
      total++;
      if (prev_valid === 1'b1) begin
        bad++;
        $display("FAIL valid_pulse: resolve_valid=1 in consecutive cycles, required single-cycle pulse");
      end
    end
    prev_valid = resolve_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int m_root(input int x);
    int r = x;
    while (m_parent[r] != r) r = m_parent[r];
    return r;
  endfunction

  function automatic int m_hops(input int x);
    int r = x;
    int h = 0;
    while (m_parent[r] != r) begin
      r = m_parent[r];
      h++;
    end
    return h;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 256; i++) m_parent[i] = i;
    m_count = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic m_alloc(input int v);
    if (v != 0) begin
      if (v > m_count) m_count = v;
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_count(input string name);
    total++;
    if (label_count !== 8'(m_count)) begin
      bad++;
      $display("FAIL %s label_count: got %0d expected %0d", name, label_count, m_count);
    end
    total++;
    if (overflow !== m_ovf) begin
      bad++;
      $display("FAIL %s overflow: got %0b expected %0b", name, overflow, m_ovf);
    end
  endtask

  task automatic do_alloc(input int v);
    new_label_valid = 1'b1;
    new_label_value = 8'(v);
    step();
    new_label_valid = 1'b0;
    m_alloc(v);
    $display("alloc %0d -> label_count=%0d overflow=%0b", v, label_count, overflow);
    check_count("alloc");
  endtask

  task automatic do_merge(input int a, input int b, input bit nlv, input int nlval);
    int exp_stall;
    int stall = 0;
    int ra, rb;
    bit active = (a != b) && (a != 0) && (b != 0);
    exp_stall = active ? (m_hops(a) + m_hops(b) + 3) : 0;
    merge_labels    = 1'b1;
    merge_a         = 8'(a);
    merge_b         = 8'(b);
    new_label_valid = nlv;
    new_label_value = 8'(nlval);
    step();
    merge_labels    = 1'b0;
    new_label_valid = 1'b0;
    if (nlv) m_alloc(nlval);
    while (!in_ready && stall < 1000) begin
      stall++;
      step();
    end
    $display("merge %0d,%0d -> stall=%0d", a, b, stall);
    total++;
    if (stall != exp_stall) begin
      bad++;
      $display("FAIL merge_stall(%0d,%0d): got %0d cycles expected %0d", a, b, stall, exp_stall);
    end
    if (active) begin
      ra = m_root(a);
      rb = m_root(b);
      if (ra < rb) m_parent[rb] = ra;
      else if (rb < ra) m_parent[ra] = rb;
    end
    check_count("merge");
  endtask

  task automatic do_resolve(input int x);
    int exp_root = m_root(x);
    int exp_lat  = m_hops(x) + 2;
    int lat = 0;
    resolve_req   = 1'b1;
    resolve_label = 8'(x);
    do begin
      step();
      lat++;
    end while (resolve_valid !== 1'b1 && lat < 1000);
    resolve_req = 1'b0;
    $display("resolve %0d -> root=%0d latency=%0d", x, resolve_root, lat);
    total++;
    if (lat != exp_lat) begin
      bad++;
      $display("FAIL resolve_latency(%0d): got %0d expected %0d", x, lat, exp_lat);
    end
    total++;
    if (resolve_root !== 8'(exp_root)) begin
      bad++;
      $display("FAIL resolve_root(%0d): got %0d expected %0d", x, resolve_root, exp_root);
    end
    step();
    total++;
    if (resolve_valid !== 1'b0 || resolve_root !== 8'(exp_root)) begin
      bad++;
      $display("FAIL resolve_hold(%0d): valid=%0b root=%0d expected valid=0 root=%0d",
               x, resolve_valid, resolve_root, exp_root);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    frame_start = 1'b0; new_label_valid = 1'b0; merge_labels = 1'b0; resolve_req = 1'b0;
    new_label_value = '0; merge_a = '0; merge_b = '0; resolve_label = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    m_clear();
    $display("reset -> in_ready=%0b resolve_valid=%0b resolve_root=%0d", in_ready, resolve_valid, resolve_root);
    total++;
    if (in_ready !== 1'b1 || resolve_valid !== 1'b0 || resolve_root !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: in_ready=%0b valid=%0b root=%0d expected 1/0/0",
               in_ready, resolve_valid, resolve_root);
    end
    check_count("reset");
  endtask

  task automatic test_alloc_resolve();
    do_alloc(1);
    do_alloc(2);
    do_alloc(3);
    do_resolve(3);
  endtask

  task automatic test_merge_basic();
    do_merge(3, 1, 1'b0, 0);
    do_resolve(3);
    do_resolve(1);
  endtask

  task automatic test_chain();
    do_alloc(4);
    do_alloc(5);
    do_merge(2, 3, 1'b0, 0);
    do_merge(4, 2, 1'b0, 0);
    do_resolve(4);
    do_resolve(2);
  endtask

  task automatic test_ignored_merges();
    int drops = 0;
    merge_labels = 1'b1;
    merge_a = 8'd5; merge_b = 8'd5;
    step();
    if (!in_ready) drops++;
    merge_a = 8'd0; merge_b = 8'd4;
    step();
    if (!in_ready) drops++;
    merge_labels = 1'b0;
    step();
    if (!in_ready) drops++;
    $display("ignored merges -> in_ready drops=%0d", drops);
    total++;
    if (drops != 0) begin
      bad++;
      $display("FAIL ignored_merge_ready: in_ready dropped %0d times, expected 0", drops);
    end
    do_resolve(5);
    do_resolve(4);
    do_resolve(0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 50; n++) begin
      do_merge($urandom_range(0, 40), $urandom_range(0, 40),
               ($urandom_range(0, 3) == 0), $urandom_range(0, 60));
    end
    for (int n = 0; n < 30; n++) begin
      do_resolve($urandom_range(0, 45));
    end
  endtask

  task automatic test_frame_abort();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    m_clear();
    for (int v = 1; v <= 6; v++) do_alloc(v);
    do_alloc(2);
    do_merge(3, 1, 1'b0, 0);
    merge_labels = 1'b1;
    merge_a = 8'd2; merge_b = 8'd3;
    step();
    merge_labels = 1'b0;
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    m_clear();
    $display("frame_start abort -> in_ready=%0b label_count=%0d", in_ready, label_count);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL frame_abort_ready: got %0b expected 1", in_ready);
    end
    check_count("frame_abort");
    do_resolve(3);
    do_resolve(2);
  endtask

  task automatic test_overflow();
    do_alloc(255);
    do_alloc(255);
    do_alloc(100);
    step();
    check_count("overflow_hold");
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_clear();
    step();
    check_count("overflow_rst");
  endtask

  initial begin
    test_reset();
    test_alloc_resolve();
    test_merge_basic();
    test_chain();
    test_ignored_merges();
    test_random();
    test_frame_abort();
    test_overflow();
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
